// File: rtl/gt_mf_pkg.sv
// Shared constants, header codes, FSM state encoding and CRC-32C step function
// for the GT metaframe scheduler.
package gt_mf_pkg;

  localparam logic [63:0] CTL_SYNC     = 64'h78F6_78F6_78F6_78F6;
  localparam logic [63:0] CTL_SKIP     = 64'h1E1E_1E1E_1E1E_1E1E;
  localparam logic [63:0] CTL_IDLE     = 64'h0700_0000_0000_0000;
  localparam logic [5:0]  CTL_SCRM_TAG = 6'h0A;
  localparam logic [5:0]  CTL_DIAG_TAG = 6'h19;

  localparam logic [1:0]  HDR_DATA = 2'b01;
  localparam logic [1:0]  HDR_CTL  = 2'b10;

  localparam logic [31:0] CRC32C_POLY = 32'h1EDC6F41;
  localparam logic [31:0] CRC32C_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    SCRM = 3'd2,
    SKIP = 3'd3,
    DATA = 3'd4,
    DIAG = 3'd5
  } mf_state_e;

  // Non-reflected CRC-32C, one 64-bit word per call, data MSB first.
  function automatic logic [31:0] crc32c_step64(input logic [31:0] crc_in,
                                                input logic [63:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 63; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC32C_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/gt_mf_crc32c.sv
// 64-bit-per-cycle parallel CRC-32C accumulator. init restarts the sum from
// all-ones; with en also set, the current word is the first one folded in.
module gt_mf_crc32c
  import gt_mf_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [63:0] data,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= CRC32C_INIT;
    end else if (en) begin
      crc <= crc32c_step64(init ? CRC32C_INIT : crc, data);
    end else if (init) begin
      crc <= CRC32C_INIT;
    end
  end

endmodule

// File: rtl/gt_metaframe_sched.sv
// Metaframe scheduler ahead of the GT TX: sync, scrambler-state, skip, payload, diag.
// Optional macro GT_MF_CRC32_EN adds a CRC-32C of words 0..LEN-2 to the diag word.
//
//  state | meaning
//  IDLE  | lane disabled, CTL_IDLE words
//  SYNC  | word 0, sync word, MF_START pulse
//  SCRM  | word 1, scrambler state snapshot
//  SKIP  | word 2, skip word
//  DATA  | words 3..LEN-2, payload or CTL_IDLE
//  DIAG  | word LEN-1, status + crc, metaframe counted
module gt_metaframe_sched
  import gt_mf_pkg::*;
#(
  parameter int METAFRAME_LEN = 2048
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET,
  input  logic        ENABLE_IN,
  input  logic        TX_PAUSE_IN,
  input  logic [57:0] SCRAM_STATE_IN,
  input  logic [1:0]  STATUS_IN,
  input  logic [63:0] DATA_IN,
  input  logic [1:0]  HEADER_IN,
  input  logic        DATA_VALID_IN,
  output logic        DATA_READY_OUT,
  output logic [63:0] TX_DATA_OUT,
  output logic [1:0]  TX_HEADER_OUT,
  output logic        MF_START_OUT,
  output logic [15:0] MF_COUNT_OUT
);

  localparam logic [15:0] LAST_DATA = 16'(METAFRAME_LEN - 2);

  mf_state_e   state;
  mf_state_e   state_nxt;
  logic [15:0] word_cnt;
  logic [63:0] word_nxt;
  logic [1:0]  hdr_nxt;
  logic [31:0] crc_field;
  logic        advance;

  assign advance        = !TX_PAUSE_IN;
  assign DATA_READY_OUT = (state == DATA) && !TX_PAUSE_IN && !SYSTEM_RESET;

  always_comb begin
    state_nxt = state;
    word_nxt  = CTL_IDLE;
    hdr_nxt   = HDR_CTL;
    case (state)
      IDLE: begin
        if (ENABLE_IN) state_nxt = SYNC;
      end
      SYNC: begin
        word_nxt  = CTL_SYNC;
        state_nxt = SCRM;
      end
      SCRM: begin
        word_nxt  = {CTL_SCRM_TAG, SCRAM_STATE_IN};
        state_nxt = SKIP;
      end
      SKIP: begin
        word_nxt  = CTL_SKIP;
        state_nxt = DATA;
      end
      DATA: begin
        // An empty slot still burns a word so DIAG never slips.
        if (DATA_VALID_IN) begin
          word_nxt = DATA_IN;
          hdr_nxt  = HEADER_IN;
        end
        if (word_cnt == LAST_DATA) state_nxt = DIAG;
      end
      DIAG: begin
        word_nxt  = {CTL_DIAG_TAG, 24'h0, STATUS_IN, crc_field};
        state_nxt = ENABLE_IN ? SYNC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      state         <= IDLE;
      word_cnt      <= 16'd0;
      TX_DATA_OUT   <= 64'd0;
      TX_HEADER_OUT <= 2'b00;
      MF_START_OUT  <= 1'b0;
      MF_COUNT_OUT  <= 16'd0;
    end else begin
      MF_START_OUT <= advance && (state == SYNC);
      if (advance) begin
        state         <= state_nxt;
        TX_DATA_OUT   <= word_nxt;
        TX_HEADER_OUT <= hdr_nxt;
        if (state == DIAG) begin
          word_cnt     <= 16'd0;
          MF_COUNT_OUT <= MF_COUNT_OUT + 16'd1;
        end else if (state != IDLE) begin
          word_cnt <= word_cnt + 16'd1;
        end
      end
    end
  end

`ifdef GT_MF_CRC32_EN
  logic [31:0] crc_reg;
  logic        crc_init;
  logic        crc_en;

  // Covers every emitted word from SYNC up to the last payload slot.
  assign crc_init = advance && (state == SYNC);
  assign crc_en   = advance && (state == SYNC || state == SCRM ||
                                state == SKIP || state == DATA);

  gt_mf_crc32c u_crc (
    .clk  (USER_CLK),
    .rst  (SYSTEM_RESET),
    .init (crc_init),
    .en   (crc_en),
    .data (word_nxt),
    .crc  (crc_reg)
  );

  assign crc_field = ~crc_reg;
`else
  assign crc_field = 32'h0;
`endif

endmodule

// File: tb/tb_gt_metaframe_sched.sv
// Scoreboard bench for gt_metaframe_sched with an 8-word metaframe.
module tb_gt_metaframe_sched;

  localparam int LEN = 8;

  localparam logic [63:0] T_SYNC = 64'h78F6_78F6_78F6_78F6;
  localparam logic [63:0] T_SKIP = 64'h1E1E_1E1E_1E1E_1E1E;
  localparam logic [63:0] T_IDLE = 64'h0700_0000_0000_0000;
  localparam logic [1:0]  H_D    = 2'b01;
  localparam logic [1:0]  H_C    = 2'b10;

  localparam int K_PLAIN = 0;
  localparam int K_SYNC  = 1;
  localparam int K_SCRM  = 2;
  localparam int K_MF    = 3;
  localparam int K_DIAG  = 4;
  localparam int K_HOLD  = 5;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  h;
    logic        s;
  } exp_t;

  logic        clk;
  logic        SYSTEM_RESET;
  logic        ENABLE_IN;
  logic        TX_PAUSE_IN;
  logic [57:0] SCRAM_STATE_IN;
  logic [1:0]  STATUS_IN;
  logic [63:0] DATA_IN;
  logic [1:0]  HEADER_IN;
  logic        DATA_VALID_IN;
  logic        DATA_READY_OUT;
  logic [63:0] TX_DATA_OUT;
  logic [1:0]  TX_HEADER_OUT;
  logic        MF_START_OUT;
  logic [15:0] MF_COUNT_OUT;

  exp_t        exp_q[$];
  exp_t        last;
  logic [31:0] crc_m;
  logic [15:0] mf_cnt_m;
  logic [63:0] next_pay;
  int          checks;
  int          errors;

  gt_metaframe_sched #(.METAFRAME_LEN(LEN)) dut (
    .USER_CLK       (clk),
    .SYSTEM_RESET   (SYSTEM_RESET),
    .ENABLE_IN      (ENABLE_IN),
    .TX_PAUSE_IN    (TX_PAUSE_IN),
    .SCRAM_STATE_IN (SCRAM_STATE_IN),
    .STATUS_IN      (STATUS_IN),
    .DATA_IN        (DATA_IN),
    .HEADER_IN      (HEADER_IN),
    .DATA_VALID_IN  (DATA_VALID_IN),
    .DATA_READY_OUT (DATA_READY_OUT),
    .TX_DATA_OUT    (TX_DATA_OUT),
    .TX_HEADER_OUT  (TX_HEADER_OUT),
    .MF_START_OUT   (MF_START_OUT),
    .MF_COUNT_OUT   (MF_COUNT_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // Byte-at-a-time CRC-32C reference, MSB first, no reflection.
  function automatic logic [31:0] crc_ref(input logic [31:0] c_in, input logic [63:0] w);
    logic [31:0] c;
    c = c_in;
    for (int b = 7; b >= 0; b--) begin
      c = c ^ {w[b*8 +: 8], 24'h0};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h1EDC6F41) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] crc_diag();
`ifdef GT_MF_CRC32_EN
    return ~crc_m;
`else
    return 32'h0;
`endif
  endfunction

  task automatic pop_compare();
    exp_t e;
    e = exp_q.pop_front();
    check("tx_data", TX_DATA_OUT, e.d);
    check("tx_header", 64'(TX_HEADER_OUT), 64'(e.h));
    check("mf_start", 64'(MF_START_OUT), 64'(e.s));
    check("mf_count", 64'(MF_COUNT_OUT), 64'(mf_cnt_m));
  endtask

  task automatic tick(input logic en, input logic pause, input logic valid,
                      input logic [63:0] din, input logic [1:0] hin, input int kind,
                      input logic exp_ready, input logic [63:0] exp_d, input logic [1:0] exp_h);
    exp_t        e;
    logic [63:0] r;
    @(negedge clk);
    r              = {$urandom(), $urandom()};
    ENABLE_IN      = en;
    TX_PAUSE_IN    = pause;
    DATA_VALID_IN  = valid;
    DATA_IN        = din;
    HEADER_IN      = hin;
    SCRAM_STATE_IN = r[57:0];
    STATUS_IN      = 2'($urandom_range(0, 3));
    e.d = exp_d;
    e.h = exp_h;
    e.s = 1'b0;
    case (kind)
      K_SYNC: begin
        e.d   = T_SYNC;
        e.h   = H_C;
        e.s   = 1'b1;
        crc_m = crc_ref(32'hFFFF_FFFF, T_SYNC);
      end
      K_SCRM: begin
        e.d   = {6'h0A, r[57:0]};
        e.h   = H_C;
        crc_m = crc_ref(crc_m, e.d);
      end
      K_MF:   crc_m = crc_ref(crc_m, exp_d);
      K_DIAG: begin
        e.d      = {6'h19, 24'h0, STATUS_IN, crc_diag()};
        e.h      = H_C;
        mf_cnt_m = mf_cnt_m + 16'd1;
      end
      K_HOLD: begin
        e.d = last.d;
        e.h = last.h;
      end
      default: ;
    endcase
    last = e;
    #1;
    check("ready", 64'(DATA_READY_OUT), 64'(exp_ready));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_compare();
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    SYSTEM_RESET  = 1'b1;
    TX_PAUSE_IN   = 1'b0;
    DATA_VALID_IN = 1'b1;
    #1;
    check("rst_ready", 64'(DATA_READY_OUT), 64'h0);
    e        = '0;
    last     = '0;
    mf_cnt_m = 16'd0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_compare();
    SYSTEM_RESET = 1'b0;
  endtask

  task automatic idle_tick(input logic en);
    tick(en, 1'b0, 1'b0, 64'h0, 2'b00, K_PLAIN, 1'b0, T_IDLE, H_C);
  endtask

  // One metaframe from SYNC: optional enable drop, pause burst, or reset abort at word w.
  task automatic run_mf(input logic [3:0] vmask, input int drop_at, input int pause_at,
                        input int pause_len, input int abort_at, input logic zero);
    for (int w = 0; w < LEN; w++) begin
      logic        en;
      logic        v;
      logic [63:0] din;
      logic [1:0]  hin;
      en  = (w < drop_at);
      din = zero ? 64'h0 : next_pay;
      hin = next_pay[3] ? H_C : H_D;
      if (w == abort_at) begin
        do_reset();
        return;
      end
      if (w == pause_at)
        repeat (pause_len) tick(en, 1'b1, 1'b1, din, hin, K_HOLD, 1'b0, 64'h0, 2'b00);
      if (w == 0)      tick(en, 1'b0, 1'b0, din, hin, K_SYNC, 1'b0, 64'h0, 2'b00);
      else if (w == 1) tick(en, 1'b0, 1'b0, din, hin, K_SCRM, 1'b0, 64'h0, 2'b00);
      else if (w == 2) tick(en, 1'b0, 1'b0, din, hin, K_MF, 1'b0, T_SKIP, H_C);
      else if (w < LEN - 1) begin
        v = vmask[w-3];
        tick(en, 1'b0, v, din, hin, K_MF, 1'b1, v ? din : T_IDLE, v ? hin : H_C);
        if (v) next_pay = next_pay + 64'd1;
      end else begin
        tick(en, 1'b0, 1'b0, din, hin, K_DIAG, 1'b0, 64'h0, 2'b00);
      end
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    next_pay       = 64'd1;
    crc_m          = 32'hFFFF_FFFF;
    mf_cnt_m       = 16'd0;
    last           = '0;
    SYSTEM_RESET   = 1'b1;
    ENABLE_IN      = 1'b0;
    TX_PAUSE_IN    = 1'b0;
    SCRAM_STATE_IN = 58'h0;
    STATUS_IN      = 2'b00;
    DATA_IN        = 64'h0;
    HEADER_IN      = 2'b00;
    DATA_VALID_IN  = 1'b0;

    do_reset();
    repeat (5) idle_tick(1'b0);

    // Full metaframe with payload 1..4, then back-to-back ones.
    idle_tick(1'b1);
    run_mf(4'b1111, 99, -1, 0, -1, 1'b0);
    run_mf(4'b1001, 99, -1, 0, -1, 1'b0);
    run_mf(4'b1111, 99, 5, 2, -1, 1'b0);
    run_mf(4'b0110, 99, 7, 1, -1, 1'b0);
    run_mf(4'b1111, 99, 0, 2, -1, 1'b0);
    run_mf(4'b1111, 99, -1, 0, -1, 1'b1);

    // Enable drops at word 2: metaframe completes, then idle.
    run_mf(4'b1111, 2, -1, 0, -1, 1'b0);
    repeat (3) idle_tick(1'b0);

    // Reset in the middle of a metaframe, then restart cleanly.
    idle_tick(1'b1);
    run_mf(4'b1111, 99, -1, 0, 4, 1'b0);
    repeat (2) idle_tick(1'b0);
    idle_tick(1'b1);
    run_mf(4'b1011, 7, -1, 0, -1, 1'b1);
    idle_tick(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
